mmio_responder: RTL and testbench

- Memory-mapped I/O responder on the CPU's mem_cmd/mem_addr/write_data/read_data bus.
- Sits beside the instruction/data RAM at top level and claims the I/O address window.
- Gives the CPU load/store access to the slide switches, the LEDs, a hex-display value, a cycle counter and a sticky switch-change flag.
- Top level muxes read_data between RAM and this block using claim_q.

---
 rtl/mmio_responder_if.sv | 33 +++
 rtl/mmio_responder.sv | 136 +++++++++++++
 tb/tb_mmio_responder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_responder_if.sv
// MMIO bus between the CPU and the I/O responder.
//   mem_cmd    : 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 treated as NONE
//   mem_addr   : word address
//   write_data : store data, valid with WRITE
//   read_data  : registered load data
//   rd_valid   : read_data holds a response this cycle
//   claim_q    : previous-cycle command hit the I/O window (read-data mux select)
interface mmio_responder_if;
  logic [1:0]  mem_cmd;
  logic [9:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        rd_valid;
  logic        claim_q;

  modport master (
    output mem_cmd,
    output mem_addr,
    output write_data,
    input  read_data,
    input  rd_valid,
    input  claim_q
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    input  write_data,
    output read_data,
    output rd_valid,
    output claim_q
  );
endinterface

// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder claiming BASE..BASE+3 on the CPU memory bus.
//   offset 0 LED    (R/W, 10 bits)
//   offset 1 HEX    (R/W, 16 bits)
//   offset 2 CYCLE  (R, write clears)
//   offset 3 STATUS (R, bit0 sticky switch-changed flag, clear-on-read)
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : slave side of the MMIO bus (command in, registered response out)
//   sw_in      : raw asynchronous slide switches
//   led_out    : LED register
//   hex_out    : hex-display register
module mmio_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter logic [9:0]  BASE        = 10'h100
) (
  input  logic                clk,
  input  logic                reset,
  mmio_responder_if.slave     bus,
  input  logic [9:0]          sw_in,
  output logic [9:0]          led_out,
  output logic [15:0]         hex_out
);

  localparam logic [1:0] CmdRead  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;

  localparam logic [1:0] OffLed    = 2'd0;
  localparam logic [1:0] OffHex    = 2'd1;
  localparam logic [1:0] OffCycle  = 2'd2;
  localparam logic [1:0] OffStatus = 2'd3;

  logic [SYNC_STAGES-1:0][9:0] sync_q, sync_d;
  logic [9:0]                  sw_prev_q, sw_prev_d;
  logic [9:0]                  led_q, led_d;
  logic [15:0]                 hex_q, hex_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        flag_q, flag_d;
  logic [15:0]                 rdata_q, rdata_d;
  logic                        rvalid_q, rvalid_d;
  logic                        claim_q, claim_d;

  logic       hit;
  logic [1:0] off;
  logic       is_rd;
  logic       is_wr;
  logic [9:0] sw_s;
  logic       chg;
  logic [15:0] cnt_ext;

  always_comb begin
    // 11-bit compare so a window near the top of the address space cannot wrap
    hit   = ({1'b0, bus.mem_addr} >= {1'b0, BASE}) &&
            ({1'b0, bus.mem_addr} <= ({1'b0, BASE} + 11'd3));
    off   = bus.mem_addr[1:0] - BASE[1:0];
    is_rd = hit && (bus.mem_cmd == CmdRead);
    is_wr = hit && (bus.mem_cmd == CmdWrite);

    sw_s = sync_q[SYNC_STAGES-1];
    chg  = (sw_s != sw_prev_q);

    cnt_ext              = '0;
    cnt_ext[CNT_W-1:0]   = cnt_q;

    sync_d[0] = sw_in;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sw_prev_d = sw_s;

    led_d    = led_q;
    hex_d    = hex_q;
    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    flag_d   = flag_q;
    rdata_d  = rdata_q;
    rvalid_d = is_rd;
    claim_d  = is_rd || is_wr;

    if (is_wr) begin
      case (off)
        OffLed:   led_d = bus.write_data[9:0];
        OffHex:   hex_d = bus.write_data;
        OffCycle: cnt_d = '0;
        default:  ;
      endcase
    end

    if (is_rd) begin
      case (off)
        OffLed:    rdata_d = {6'b0, led_q};
        OffHex:    rdata_d = hex_q;
        OffCycle:  rdata_d = cnt_ext;
        OffStatus: rdata_d = {15'b0, flag_q};
        default:   rdata_d = rdata_q;
      endcase
    end

    // A change on the clearing edge must not be lost, so set beats clear
    if (chg) begin
      flag_d = 1'b1;
    end else if (is_rd && (off == OffStatus)) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      sw_prev_q <= '0;
      led_q     <= '0;
      hex_q     <= '0;
      cnt_q     <= '0;
      flag_q    <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      claim_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      sw_prev_q <= sw_prev_d;
      led_q     <= led_d;
      hex_q     <= hex_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      claim_q   <= claim_d;
    end
  end

  assign bus.read_data = rdata_q;
  assign bus.rd_valid  = rvalid_q;
  assign bus.claim_q   = claim_q;
  assign led_out       = led_q;
  assign hex_out       = hex_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed test-plan scenarios plus a
// randomized phase, all compared against a behavioural model of the register map.
module tb_mmio_responder;

  localparam int SyncStages = 2;
  localparam int Base       = 'h100;

  logic       clk;
  logic       reset;
  logic [9:0] sw_in;
  logic [9:0] led_out;
  logic [15:0] hex_out;

  mmio_responder_if bus();

  mmio_responder #(
    .SYNC_STAGES(SyncStages),
    .CNT_W      (16),
    .BASE       (10'h100)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .sw_in  (sw_in),
    .led_out(led_out),
    .hex_out(hex_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_led, m_hex, m_cnt, m_flag, m_rdata, m_rvalid, m_claim;
  int sw_hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int hist_at(input int back);
    // sw_in value sampled 'back' edges ago (1 = last edge); 0 before any sampling
    if (sw_hist.size() >= back) return sw_hist[sw_hist.size() - back];
    return 0;
  endfunction

  task automatic model_reset();
    m_led = 0; m_hex = 0; m_cnt = 0; m_flag = 0;
    m_rdata = 0; m_rvalid = 0; m_claim = 0;
    sw_hist.delete();
  endtask

  task automatic model_step(input int cmd, input int addr, input int wd, input int sw);
    int  off;
    bit  hit, rd, wr, chg;
    hit = (addr >= Base) && (addr <= Base + 3);
    off = addr - Base;
    rd  = hit && (cmd == 1);
    wr  = hit && (cmd == 2);
    // Synchronized view lags raw input by SyncStages edges; prev lags one more
    chg = hist_at(SyncStages) != hist_at(SyncStages + 1);
    if (rd) begin
      if (off == 0) m_rdata = m_led;
      else if (off == 1) m_rdata = m_hex;
      else if (off == 2) m_rdata = m_cnt;
      else m_rdata = m_flag;
    end
    m_rvalid = rd;
    m_claim  = rd || wr;
    if (wr && off == 2) m_cnt = 0;
    else m_cnt = (m_cnt + 1) % 65536;
    if (wr && off == 0) m_led = wd % 1024;
    if (wr && off == 1) m_hex = wd;
    if (chg) m_flag = 1;
    else if (rd && off == 3) m_flag = 0;
    sw_hist.push_back(sw);
    if (sw_hist.size() > SyncStages + 2) void'(sw_hist.pop_front());
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_rvalid));
    check({tag, ".claim_q"}, 32'(bus.claim_q), 32'(m_claim));
    check({tag, ".read_data"}, 32'(bus.read_data), 32'(m_rdata));
    check({tag, ".led_out"}, 32'(led_out), 32'(m_led));
    check({tag, ".hex_out"}, 32'(hex_out), 32'(m_hex));
  endtask

  // One bus cycle: drive inputs, advance model and DUT by one edge, compare after it
  task automatic cyc(input logic [1:0] cmd, input logic [9:0] addr, input logic [15:0] wd,
                     input string tag);
    bus.mem_cmd    = cmd;
    bus.mem_addr   = addr;
    bus.write_data = wd;
    model_step(int'(cmd), int'(addr), int'(wd), int'(sw_in));
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 10'h000, 16'h0000, "idle");
  endtask

  task automatic pulse_reset();
    #2;
    bus.mem_cmd = 2'b00;
    reset = 1'b1;
    #1;
    check("rst.rd_valid", 32'(bus.rd_valid), 32'h0);
    check("rst.claim_q", 32'(bus.claim_q), 32'h0);
    check("rst.read_data", 32'(bus.read_data), 32'h0);
    check("rst.led_out", 32'(led_out), 32'h0);
    check("rst.hex_out", 32'(hex_out), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0]  rcmd;
    logic [9:0]  raddr;
    logic [15:0] rwd;

    reset          = 1'b1;
    sw_in          = '0;
    bus.mem_cmd    = 2'b00;
    bus.mem_addr   = '0;
    bus.write_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Cycle counter reads 0 on the first edge after release
    cyc(2'b01, 10'h102, 16'h0, "cyc0");
    check("cycle_after_reset", 32'(bus.read_data), 32'h0);

    // LED write/read
    cyc(2'b10, 10'h100, 16'hFFFF, "wr_led");
    check("led_all_ones", 32'(led_out), 32'h3FF);
    cyc(2'b01, 10'h100, 16'h0, "rd_led");
    check("rd_led.data", 32'(bus.read_data), 32'h03FF);
    check("rd_led.valid", 32'(bus.rd_valid), 32'h1);
    check("rd_led.claim", 32'(bus.claim_q), 32'h1);

    // HEX write then back-to-back reads
    cyc(2'b10, 10'h101, 16'hBEEF, "wr_hex");
    cyc(2'b01, 10'h101, 16'h0, "rd_hex");
    check("b2b.hex", 32'(bus.read_data), 32'hBEEF);
    cyc(2'b01, 10'h100, 16'h0, "rd_led2");
    check("b2b.led", 32'(bus.read_data), 32'h03FF);
    check("b2b.valid", 32'(bus.rd_valid), 32'h1);

    // Reset mid-read clears rd_valid asynchronously
    cyc(2'b01, 10'h101, 16'h0, "rd_before_rst");
    check("pre_rst.valid", 32'(bus.rd_valid), 32'h1);
    pulse_reset();

    // Counter wrap over a long free run, then clear and read 5 cycles later
    idle(70000);
    cyc(2'b01, 10'h102, 16'h0, "rd_wrap");
    check("wrap.cycle", 32'(bus.read_data), 32'((70000) % 65536));
    cyc(2'b10, 10'h102, 16'h1234, "clr_cnt");
    idle(4);
    cyc(2'b01, 10'h102, 16'h0, "rd_cnt5");
    check("clr.cycle", 32'(bus.read_data), 32'h0004);

    // Switch change flag: set SyncStages+1 edges after the toggle
    sw_in[3] = ~sw_in[3];
    cyc(2'b00, 10'h000, 16'h0, "tog");
    idle(SyncStages);
    cyc(2'b01, 10'h103, 16'h0, "rd_st1");
    check("status.set", 32'(bus.read_data), 32'h1);
    cyc(2'b01, 10'h103, 16'h0, "rd_st2");
    check("status.cleared", 32'(bus.read_data), 32'h0);

    // Toggle aligned with the clearing edge: set wins
    sw_in[3] = ~sw_in[3];
    cyc(2'b00, 10'h000, 16'h0, "tog_a");
    sw_in[3] = ~sw_in[3];
    cyc(2'b00, 10'h000, 16'h0, "tog_b");
    cyc(2'b00, 10'h000, 16'h0, "wait_set");
    cyc(2'b01, 10'h103, 16'h0, "rd_st3");
    check("status.collide1", 32'(bus.read_data), 32'h1);
    cyc(2'b01, 10'h103, 16'h0, "rd_st4");
    check("status.collide2", 32'(bus.read_data), 32'h1);
    cyc(2'b01, 10'h103, 16'h0, "rd_st5");
    check("status.collide3", 32'(bus.read_data), 32'h0);

    // Out-of-window and reserved command
    cyc(2'b01, 10'h104, 16'h0, "rd_104");
    check("miss104.valid", 32'(bus.rd_valid), 32'h0);
    cyc(2'b01, 10'h0FF, 16'h0, "rd_0ff");
    check("miss0ff.claim", 32'(bus.claim_q), 32'h0);
    cyc(2'b10, 10'h104, 16'h5555, "wr_104");
    check("miss_wr.led", 32'(led_out), 32'h0);
    cyc(2'b11, 10'h100, 16'hAAAA, "cmd11");
    check("cmd11.led", 32'(led_out), 32'h0);
    check("cmd11.claim", 32'(bus.claim_q), 32'h0);

    // Write immediately followed by read of same offset
    cyc(2'b10, 10'h101, 16'h1357, "wr_then");
    cyc(2'b01, 10'h101, 16'h0, "rd_now");
    check("wr_rd.hex", 32'(bus.read_data), 32'h1357);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rcmd = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       raddr = 10'h0FF;
        1:       raddr = 10'h104;
        2:       raddr = 10'($urandom);
        default: raddr = 10'h100 + 10'($urandom_range(0, 3));
      endcase
      rwd = 16'($urandom);
      if ($urandom_range(0, 5) == 0) sw_in[$urandom_range(0, 9)] ^= 1'b1;
      cyc(rcmd, raddr, rwd, "rand");
      if ($urandom_range(0, 999) == 0) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
